// File: rtl/countdown_timer_gen.sv
`default_nettype none
// countdown_timer_gen: BCD countdown timer with SET/RUN/PAUSE control, a tick
// prescaler with fast mode, optional auto-reload and a remaining-time LED bar.
module countdown_timer_gen #(
  parameter int TICK_DIV = 5000,
  parameter int FAST_DIV = 50,
  parameter int BAR_W    = 18,
  parameter int HOUR_MAX = 99
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             FAST,
  input  logic             RELOAD_EN,
  input  logic             KEY_SEL,
  input  logic             KEY_UP,
  input  logic             KEY_DN,
  input  logic             KEY_GO,
  output logic [3:0]       TSEC0,
  output logic [3:0]       TSEC1,
  output logic [3:0]       TMIN0,
  output logic [3:0]       TMIN1,
  output logic [3:0]       THOUR0,
  output logic [3:0]       THOUR1,
  output logic [BAR_W-1:0] BAR,
  output logic [1:0]       FIELD,
  output logic             RUNNING,
  output logic             DONE
);

  localparam int         PW     = $clog2(TICK_DIV + 1);
  localparam int         PRODW  = 26;
  localparam logic [7:0] SM_MAX = 8'h59;
  localparam logic [7:0] HR_MAX = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       field_q, field_d;
  logic [23:0]      digits_q, digits_d;
  logic [18:0]      rem_q, rem_d;
  logic [23:0]      pre_dig_q, pre_dig_d;
  logic [18:0]      pre_rem_q, pre_rem_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic [BAR_W-1:0] bar_q, bar_d;
  logic [3:0]       sync1_q, sync2_q, prev_q;

  logic             sel_ev, up_ev, dn_ev, go_ev;
  logic [PW-1:0]    div;
  logic             tick;
  logic [7:0]       fld_bcd, fld_max, fld_new;
  logic [18:0]      fld_unit, fld_span, rem_edit;
  logic [PRODW-1:0] rem_scaled;
  logic [BAR_W-1:0] bar_run;

  assign {go_ev, dn_ev, up_ev, sel_ev} = sync2_q & ~prev_q;
  assign div = FAST ? PW'(FAST_DIV) : PW'(TICK_DIV);

  function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dn(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00) return vmax;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // One-second borrow chain; only ever applied to a non-zero time.
  function automatic logic [23:0] bcd_sec_dec(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (t[15:12] != 4'd0) r[15:12] = t[15:12] - 4'd1;
          else begin
            r[15:12] = 4'd5;
            if (t[19:16] != 4'd0) r[19:16] = t[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              r[23:20] = t[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Lit LED k (from the MSB) when REM*BAR_W > k*preset.
  assign rem_scaled = PRODW'(rem_q) * PRODW'(BAR_W);
  for (genvar k = 0; k < BAR_W; k++) begin : g_bar
    assign bar_run[BAR_W-1-k] = rem_scaled > (PRODW'(k) * PRODW'(pre_rem_q));
  end

  always_comb begin
    fld_bcd  = digits_q[7:0];
    fld_max  = SM_MAX;
    fld_unit = 19'd1;
    fld_span = 19'd59;
    case (field_q)
      2'd1: begin
        fld_bcd  = digits_q[15:8];
        fld_unit = 19'd60;
        fld_span = 19'd3540;
      end
      2'd2: begin
        fld_bcd  = digits_q[23:16];
        fld_max  = HR_MAX;
        fld_unit = 19'd3600;
        fld_span = 19'(HOUR_MAX * 3600);
      end
      default: ;
    endcase
    if (up_ev) begin
      fld_new  = bcd_up(fld_bcd, fld_max);
      rem_edit = (fld_bcd == fld_max) ? rem_q - fld_span : rem_q + fld_unit;
    end else begin
      fld_new  = bcd_dn(fld_bcd, fld_max);
      rem_edit = (fld_bcd == 8'h00) ? rem_q + fld_span : rem_q - fld_unit;
    end
  end

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    digits_d  = digits_q;
    rem_d     = rem_q;
    pre_dig_d = pre_dig_q;
    pre_rem_d = pre_rem_q;
    presc_d   = presc_q;
    done_d    = 1'b0;
    tick      = 1'b0;
    bar_d     = (state_q == ST_SET) ? {BAR_W{rem_q != 19'd0}} : bar_run;
    if (!EN) begin
      state_d   = ST_SET;
      field_d   = 2'd0;
      digits_d  = '0;
      rem_d     = '0;
      pre_dig_d = '0;
      pre_rem_d = '0;
      presc_d   = '0;
      bar_d     = '0;
    end else begin
      case (state_q)
        ST_SET: begin
          if (go_ev) begin
            if (rem_q != 19'd0) begin
              pre_dig_d = digits_q;
              pre_rem_d = rem_q;
              presc_d   = '0;
              state_d   = ST_RUN;
            end
          end else begin
            if (sel_ev) field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
            if (up_ev ^ dn_ev) begin
              rem_d = rem_edit;
              case (field_q)
                2'd1:    digits_d[15:8]  = fld_new;
                2'd2:    digits_d[23:16] = fld_new;
                default: digits_d[7:0]   = fld_new;
              endcase
            end
          end
        end
        ST_RUN: begin
          // A count left above a newly shortened divisor wraps silently.
          if (presc_q >= div) presc_d = '0;
          else if (presc_q == div - PW'(1)) begin
            presc_d = '0;
            tick    = 1'b1;
          end else presc_d = presc_q + PW'(1);
          if (go_ev) state_d = ST_PAUSE;
          if (tick) begin
            if (rem_q == 19'd1) begin
              done_d   = 1'b1;
              digits_d = pre_dig_q;
              rem_d    = pre_rem_q;
              if (!RELOAD_EN) begin
                state_d = ST_SET;
                field_d = 2'd0;
              end
            end else begin
              digits_d = bcd_sec_dec(digits_q);
              rem_d    = rem_q - 19'd1;
            end
          end
        end
        ST_PAUSE: if (go_ev) state_d = ST_RUN;
        default:  state_d = ST_SET;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      state_q   <= ST_SET;
      field_q   <= '0;
      digits_q  <= '0;
      rem_q     <= '0;
      pre_dig_q <= '0;
      pre_rem_q <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      bar_q     <= '0;
    end else begin
      sync1_q   <= {KEY_GO, KEY_DN, KEY_UP, KEY_SEL};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      field_q   <= field_d;
      digits_q  <= digits_d;
      rem_q     <= rem_d;
      pre_dig_q <= pre_dig_d;
      pre_rem_q <= pre_rem_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      bar_q     <= bar_d;
    end
  end

  assign {THOUR1, THOUR0, TMIN1, TMIN0, TSEC1, TSEC0} = digits_q;
  assign BAR     = bar_q;
  assign FIELD   = field_q;
  assign RUNNING = (state_q == ST_RUN);
  assign DONE    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_gen.sv
`default_nettype none
// tb_countdown_timer_gen: directed key/switch stimulus, checked every cycle
// against an integer-seconds reference model plus hand-computed expectations.
module tb_countdown_timer_gen;

  localparam int TD = 40;
  localparam int FD = 4;
  localparam int BW = 18;
  localparam int HM = 23;

  localparam int M_EDIT  = 10;
  localparam int M_COUNT = 11;
  localparam int M_HOLD  = 12;

  localparam logic [3:0] K_SEL = 4'b0001;
  localparam logic [3:0] K_UP  = 4'b0010;
  localparam logic [3:0] K_DN  = 4'b0100;
  localparam logic [3:0] K_GO  = 4'b1000;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          EN = 1'b0;
  logic          FAST = 1'b1;
  logic          RELOAD_EN = 1'b0;
  logic [3:0]    keys = 4'b0000;
  logic [3:0]    TSEC0, TSEC1, TMIN0, TMIN1, THOUR0, THOUR1;
  logic [BW-1:0] BAR;
  logic [1:0]    FIELD;
  logic          RUNNING, DONE;

  int n_checks = 0;
  int n_pass   = 0;

  countdown_timer_gen #(
    .TICK_DIV(TD), .FAST_DIV(FD), .BAR_W(BW), .HOUR_MAX(HM)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .FAST(FAST), .RELOAD_EN(RELOAD_EN),
    .KEY_SEL(keys[0]), .KEY_UP(keys[1]), .KEY_DN(keys[2]), .KEY_GO(keys[3]),
    .TSEC0(TSEC0), .TSEC1(TSEC1), .TMIN0(TMIN0), .TMIN1(TMIN1),
    .THOUR0(THOUR0), .THOUR1(THOUR1), .BAR(BAR), .FIELD(FIELD),
    .RUNNING(RUNNING), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model: time held as plain seconds ----------------
  int            m_state = M_EDIT;
  int            m_rem = 0, m_pre = 0, m_field = 0, m_presc = 0;
  bit            m_done = 1'b0;
  logic [BW-1:0] m_bar = '0;
  logic [3:0]    kh0 = '0, kh1 = '0, kh2 = '0;

  function automatic logic [BW-1:0] bar_of(input int st, input int rem, input int pre);
    int lit;
    logic [63:0] msk;
    if (st == M_EDIT) lit = (rem != 0) ? BW : 0;
    else if (pre == 0) lit = 0;
    else begin
      lit = (rem * BW + pre - 1) / pre;
      if (lit > BW) lit = BW;
    end
    msk = (64'd1 << (BW - lit)) - 64'd1;
    return ~msk[BW-1:0];
  endfunction

  task automatic model_step();
    logic [3:0] ev;
    int div, hh, mm, ss;
    bit tk;
    if (!RSTN) begin
      m_state = M_EDIT; m_rem = 0; m_pre = 0; m_field = 0; m_presc = 0;
      m_done = 1'b0; m_bar = '0; kh0 = '0; kh1 = '0; kh2 = '0;
      return;
    end
    ev  = kh1 & ~kh2;
    kh2 = kh1; kh1 = kh0; kh0 = keys;
    m_done = 1'b0;
    if (!EN) begin
      m_state = M_EDIT; m_rem = 0; m_pre = 0; m_field = 0; m_presc = 0; m_bar = '0;
      return;
    end
    m_bar = bar_of(m_state, m_rem, m_pre);
    div = FAST ? FD : TD;
    case (m_state)
      M_EDIT: begin
        if (ev[3]) begin
          if (m_rem > 0) begin m_pre = m_rem; m_presc = 0; m_state = M_COUNT; end
        end else begin
          if (ev[1] != ev[2]) begin
            hh = m_rem / 3600; mm = (m_rem / 60) % 60; ss = m_rem % 60;
            case (m_field)
              0: ss = ev[1] ? (ss + 1) % 60 : (ss + 59) % 60;
              1: mm = ev[1] ? (mm + 1) % 60 : (mm + 59) % 60;
              default: hh = ev[1] ? (hh + 1) % (HM + 1) : (hh + HM) % (HM + 1);
            endcase
            m_rem = hh * 3600 + mm * 60 + ss;
          end
          if (ev[0]) m_field = (m_field + 1) % 3;
        end
      end
      M_COUNT: begin
        tk = 1'b0;
        if (m_presc >= div) m_presc = 0;
        else if (m_presc == div - 1) begin m_presc = 0; tk = 1'b1; end
        else m_presc++;
        if (ev[3]) m_state = M_HOLD;
        if (tk) begin
          if (m_rem == 1) begin
            m_done = 1'b1;
            m_rem  = m_pre;
            if (!RELOAD_EN) begin m_state = M_EDIT; m_field = 0; end
          end else m_rem--;
        end
      end
      default: if (ev[3]) m_state = M_COUNT;
    endcase
  endtask

  initial forever begin
    @(posedge CLK or negedge RSTN);
    model_step();
  end

  initial forever begin
    int hh, mm, ss;
    logic [63:0] exp_v, got_v;
    @(posedge CLK);
    #1;
    hh = m_rem / 3600; mm = (m_rem / 60) % 60; ss = m_rem % 60;
    exp_v = {18'd0, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10),
             4'(ss % 10), m_bar, 2'(m_field), 1'(m_state == M_COUNT), m_done};
    got_v = {18'd0, THOUR1, THOUR0, TMIN1, TMIN0, TSEC1, TSEC0, BAR, FIELD, RUNNING, DONE};
    check("cycle {digits,bar,field,running,done}", got_v, exp_v);
  end

  // ---------------- stimulus (all tasks start and end on a falling edge) ----------------
  task automatic tick_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] mask);
    keys = mask;
    @(negedge CLK);
    keys = 4'b0000;
    tick_n(2);
  endtask

  task automatic clear_en();
    EN = 1'b0;
    @(negedge CLK);
    EN = 1'b1;
  endtask

  logic [BW-1:0] bar5 [4];
  int waited, pulses, run_lo, bad;
  bit found;

  initial begin
    bar5[0] = 18'h3FFF8; bar5[1] = 18'h3FF80; bar5[2] = 18'h3FC00; bar5[3] = 18'h3C000;
    tick_n(2);
    check("reset_outputs", {TSEC0, TSEC1, TMIN0, TMIN1, THOUR0, THOUR1, BAR, FIELD, RUNNING, DONE}, 64'd0);
    RSTN = 1'b1;
    EN   = 1'b1;

    repeat (3) press(K_UP);
    check("sec_up_x3", {TSEC1, TSEC0}, 8'h03);
    press(K_GO);
    tick_n(2);
    check("running_before_reset", RUNNING, 1'b1);
    @(posedge CLK);
    #3 RSTN = 1'b0;
    #1 check("async_reset_clears", {TSEC0, TSEC1, TMIN0, TMIN1, THOUR0, THOUR1, BAR, FIELD, RUNNING, DONE}, 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;

    press(K_DN);
    check("sec_dn_wrap", {TSEC1, TSEC0}, 8'h59);
    press(K_SEL); check("field_1", FIELD, 2'd1);
    press(K_SEL); check("field_2", FIELD, 2'd2);
    press(K_SEL); check("field_wrap_0", FIELD, 2'd0);
    press(K_SEL); press(K_SEL);
    press(K_DN);
    check("hour_dn_wrap", {THOUR1, THOUR0}, 8'h23);
    press(K_UP);
    check("hour_up_wrap", {THOUR1, THOUR0}, 8'h00);
    press(K_SEL);
    press(K_UP | K_DN);
    check("up_dn_same_cycle", {THOUR1, THOUR0, TMIN1, TMIN0, TSEC1, TSEC0}, 24'h000059);

    clear_en();
    press(K_GO);
    check("go_with_zero", RUNNING, 1'b0);

    // Countdown from 00:01:00 at DIV = FAST_DIV = 4
    press(K_SEL); press(K_UP); press(K_SEL); press(K_SEL);
    check("bar_set_nonzero", BAR, {BW{1'b1}});
    press(K_GO);
    tick_n(3);
    check("before_first_tick", {TMIN1, TMIN0, TSEC1, TSEC0}, 16'h0100);
    tick_n(1);
    check("first_tick_borrow", {TMIN1, TMIN0, TSEC1, TSEC0}, 16'h0059);
    found = 1'b0; waited = 0;
    for (int i = 1; i <= 400 && !found; i++) begin
      @(negedge CLK);
      if (DONE) begin found = 1'b1; waited = i; end
    end
    check("expiry_latency", waited, 236);
    check("expiry_loads_preset", {THOUR1, THOUR0, TMIN1, TMIN0, TSEC1, TSEC0}, 24'h000100);
    check("expiry_to_set", RUNNING, 1'b0);
    tick_n(1);
    check("done_single_cycle", DONE, 1'b0);

    // Pause / resume
    clear_en();
    repeat (10) press(K_UP);
    press(K_GO);
    press(K_GO);
    check("paused", RUNNING, 1'b0);
    tick_n(20);
    press(K_UP); press(K_DN); press(K_SEL);
    check("pause_digits_frozen", {TSEC1, TSEC0}, 8'h10);
    check("pause_field_frozen", FIELD, 2'd0);
    press(K_GO);
    check("resume_running", RUNNING, 1'b1);
    check("resume_no_tick_yet", {TSEC1, TSEC0}, 8'h10);
    tick_n(1);
    check("resume_tick", {TSEC1, TSEC0}, 8'h09);

    EN = 1'b0;
    @(negedge CLK);
    check("en_drop_clears", {TSEC0, TSEC1, TMIN0, TMIN1, THOUR0, THOUR1, BAR, FIELD, RUNNING, DONE}, 64'd0);
    EN = 1'b1;

    // Auto-reload with preset 00:00:02
    RELOAD_EN = 1'b1;
    press(K_UP); press(K_UP);
    press(K_GO);
    pulses = 0; run_lo = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) pulses++;
      if (!RUNNING) run_lo++;
      if (!({TSEC1, TSEC0} == 8'h01 || {TSEC1, TSEC0} == 8'h02)) bad++;
    end
    check("reload_done_pulses", pulses, 5);
    check("reload_stays_running", run_lo, 0);
    check("reload_digit_range", bad, 0);
    clear_en();
    RELOAD_EN = 1'b0;

    // Bar with preset 00:00:18
    repeat (18) press(K_UP);
    check("preset_18", {TSEC1, TSEC0}, 8'h18);
    press(K_GO);
    check("bar18_start_full", BAR, {BW{1'b1}});
    tick_n(5);
    check("bar18_rem17", BAR, 18'h3FFFE);
    tick_n(65);
    check("bar18_rem1_msb_only", BAR, 18'h20000);
    clear_en();

    // Bar with preset 00:00:05 -> lit 18,15,11,8,4
    repeat (5) press(K_UP);
    press(K_GO);
    tick_n(1);
    check("bar5_rem5", BAR, {BW{1'b1}});
    for (int i = 0; i < 4; i++) begin
      tick_n(4);
      check("bar5_step", BAR, bar5[i]);
    end
    clear_en();

    // FAST raised while the normal-mode count sits at 30
    FAST = 1'b0;
    repeat (5) press(K_UP);
    press(K_GO);
    tick_n(30);
    FAST = 1'b1;
    tick_n(1);
    check("fast_wrap_no_tick", {TSEC1, TSEC0}, 8'h05);
    tick_n(3);
    check("fast_count_restart", {TSEC1, TSEC0}, 8'h05);
    tick_n(1);
    check("fast_first_tick", {TSEC1, TSEC0}, 8'h04);
    tick_n(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
